key_matrix_scan: RTL and testbench



---
 rtl/key_matrix_scan.sv | 150 +++++++++++++++
 tb/tb_key_matrix_scan.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/key_matrix_scan.sv
// Row-scanned key matrix reader: drives one row low per scan tick, assembles whole-matrix
// frames from synchronized active-low columns, debounces frames and reports single presses.
module key_matrix_scan #(
  parameter int F_CLK    = 50000000,
  parameter int F_SCAN   = 1000,
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [ROWS-1:0]                row_n,
  input  logic [COLS-1:0]                col_n,
  output logic [$clog2(ROWS*COLS)-1:0]   key_code,
  output logic                           key_valid,
  output logic                           key_pressed,
  output logic                           key_multi
);

  localparam int TICK_DIV = F_CLK / F_SCAN;
  localparam int CNT_W    = $clog2(TICK_DIV);
  localparam int PTR_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int N        = ROWS * COLS;
  localparam int CODE_W   = $clog2(N);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(ROWS - 1);
  localparam logic [3:0]       DB        = 4'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, PRESSED, BLOCKED} state_t;

  logic [COLS-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ROWS-1:0]   row_n_q, row_n_d;
  logic [N-1:0]      frame_q, frame_d;
  logic [N-1:0]      cand_q, cand_d;
  logic [N-1:0]      stable_q, stable_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              tick, frame_done;
  logic              n_zero, n_one;
  logic [CODE_W-1:0] set_idx;
  int                base;

  state_t            state_q;
  logic [CODE_W-1:0] key_code_q;
  logic              key_valid_q;

  always_comb begin
    sync1_d    = col_n;
    sync2_d    = sync1_q;
    tick       = (tick_cnt_q == TICK_LAST);
    frame_done = tick && (ptr_q == PTR_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    ptr_d = ptr_q;
    if (tick) ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    row_n_d = ~(ROWS'(1) << ptr_d);

    // Columns are inverted here so every frame bit reads 1 = pressed.
    base    = int'(ptr_q) * COLS;
    frame_d = frame_q;
    if (tick) frame_d[base +: COLS] = ~sync2_q;

    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (frame_done) begin
      if (frame_d == cand_q) begin
        cnt_d = (cnt_q >= DB) ? DB : cnt_q + 4'd1;
        if (cnt_d == DB) stable_d = cand_q;
      end else begin
        cand_d = frame_d;
        cnt_d  = 4'd1;
        if (DB == 4'd1) stable_d = frame_d;
      end
    end
  end

  // Popcount reduced to the three classes the FSM cares about.
  always_comb begin
    n_zero  = (stable_q == '0);
    n_one   = !n_zero && ((stable_q & (stable_q - 1'b1)) == '0);
    set_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (stable_q[i]) set_idx = CODE_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      tick_cnt_q <= '0;
      ptr_q      <= '0;
      row_n_q    <= ~(ROWS'(1));
      frame_q    <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      ptr_q      <= ptr_d;
      row_n_q    <= row_n_d;
      frame_q    <= frame_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
    end
  end

  // A pressed key is remembered as key_code; any other nonzero stable frame blocks rollover.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (n_one) begin
            state_q     <= PRESSED;
            key_code_q  <= set_idx;
            key_valid_q <= 1'b1;
          end else if (!n_zero) begin
            state_q <= BLOCKED;
          end
        end
        PRESSED: begin
          if (n_zero) state_q <= IDLE;
          else if (stable_q != (N'(1) << key_code_q)) state_q <= BLOCKED;
        end
        BLOCKED: begin
          if (n_zero) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign row_n       = row_n_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = (state_q == PRESSED);
  assign key_multi   = (state_q == BLOCKED);

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan: a behavioural 4x4 key matrix answers the row drive,
// and every observation is compared against hand-derived values.
module tb_key_matrix_scan;

  localparam int FRAME = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid, key_pressed, key_multi;
  logic [15:0] keys = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;
  int base_p;
  logic [3:0] last_code = '0;

  key_matrix_scan #(
    .F_CLK(16), .F_SCAN(1), .ROWS(4), .COLS(4), .DEBOUNCE(3)
  ) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid),
    .key_pressed(key_pressed), .key_multi(key_multi)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key shorts its row line to its column line.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) col_n = ~keys[r*4 +: 4];
    end
  end

  always @(negedge clk) begin
    if (key_valid) begin
      pulses    <= pulses + 1;
      last_code <= key_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] k);
    rst  = 1'b1;
    keys = k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_pulse(input int limit);
    for (int i = 0; i < limit && pulses == base_p; i++) step();
  endtask

  initial begin
    int bad;
    int idx;
    logic [3:0] prev_row;
    logic [3:0] exp_row;

    // Reset state
    do_reset(16'h0000);
    check("rst_row_n", row_n, 4'b1110);
    check("rst_code", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_pressed", key_pressed, 0);
    check("rst_multi", key_multi, 0);

    // Scan rotation with nothing pressed
    base_p = pulses;
    bad = 0;
    for (int k = 1; k <= 128; k++) begin
      step();
      idx = (k / 16) % 4;
      exp_row = 4'b1111;
      exp_row[idx] = 1'b0;
      if (row_n !== exp_row) bad++;
      if (k == 16) check("row1_enter", row_n, 4'b1101);
      if (k == 63) check("row3_hold", row_n, 4'b0111);
      if (k == 64) check("row_wrap", row_n, 4'b1110);
    end
    check("scan_rot_errs", bad, 0);
    check("scan_no_valid", pulses - base_p, 0);

    // Clean press of key 9, then release
    do_reset(16'h0200);
    base_p = pulses;
    wait_pulse(4 * FRAME + 4);
    check("k9_pulse", pulses - base_p, 1);
    check("k9_code", last_code, 9);
    check("k9_pressed", key_pressed, 1);
    repeat (2 * FRAME) step();
    check("k9_single", pulses - base_p, 1);
    keys = 16'h0000;
    repeat (100) step();
    check("k9_hold_deb", key_pressed, 1);
    for (int i = 0; i < 3 * FRAME && key_pressed; i++) step();
    check("k9_release", key_pressed, 0);

    // Bouncing contact on key 9 before it settles
    do_reset(16'h0000);
    repeat (10) step();
    base_p = pulses;
    for (int t = 0; t < 10; t++) begin
      keys = (t % 2 == 0) ? 16'h0200 : 16'h0000;
      repeat (20) step();
    end
    keys = 16'h0200;
    wait_pulse(5 * FRAME);
    repeat (2 * FRAME) step();
    check("bounce_pulses", pulses - base_p, 1);
    check("bounce_code", last_code, 9);

    // Keys 0 and 5 together: rollover blocked
    do_reset(16'h0021);
    base_p = pulses;
    for (int i = 0; i < 5 * FRAME && !key_multi; i++) step();
    check("multi_set", key_multi, 1);
    check("multi_no_valid", pulses - base_p, 0);
    keys = 16'h0001;
    repeat (5 * FRAME) step();
    check("multi_keep", key_multi, 1);
    check("multi_not_pressed", key_pressed, 0);
    check("multi_no_valid2", pulses - base_p, 0);
    keys = 16'h0000;
    for (int i = 0; i < 5 * FRAME && key_multi; i++) step();
    check("multi_clear", key_multi, 0);
    check("multi_idle_pressed", key_pressed, 0);

    // Key 3 swapped for key 12 within one frame
    do_reset(16'h0008);
    base_p = pulses;
    wait_pulse(5 * FRAME);
    check("k3_code", last_code, 3);
    base_p = pulses;
    repeat (20) step();
    keys = 16'h1000;
    for (int i = 0; i < 5 * FRAME && !key_multi; i++) step();
    check("swap_blocked", key_multi, 1);
    check("swap_no_pulse", pulses - base_p, 0);
    keys = 16'h0000;
    for (int i = 0; i < 5 * FRAME && key_multi; i++) step();
    check("swap_idle", key_multi, 0);
    repeat (7) step();
    keys = 16'h1000;
    wait_pulse(5 * FRAME);
    check("k12_pulse", pulses - base_p, 1);
    check("k12_code", last_code, 12);

    // Reset 40 cycles into a frame while key 9 is held
    do_reset(16'h0200);
    base_p = pulses;
    wait_pulse(5 * FRAME);
    check("pre_rst_pressed", key_pressed, 1);
    prev_row = row_n;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (prev_row == 4'b0111 && row_n == 4'b1110) break;
      prev_row = row_n;
    end
    check("frame_start_found", row_n, 4'b1110);
    repeat (39) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_row_n", row_n, 4'b1110);
    check("mid_rst_pressed", key_pressed, 0);
    check("mid_rst_code", key_code, 0);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_multi", key_multi, 0);
    base_p = pulses;
    repeat (150) step();
    check("post_rst_early", pulses - base_p, 0);
    wait_pulse(50);
    check("post_rst_pulse", pulses - base_p, 1);
    check("post_rst_code", last_code, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
